// File: rtl/div_pkg.sv
// Shared definitions for the divider request sequencer: default widths,
// FSM state encoding and result error codes.
package div_pkg;

    localparam int DEF_L_DIVN = 8;
    localparam int DEF_L_DIVR = 4;
    localparam int DEF_TAG_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RECOVER   = 3'd4,
        S_HOLD      = 3'd5
    } div_state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_DIVERR  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/div_req_fifo.sv
// Small synchronous FIFO holding packed {dividend, divisor, tag} requests.
// A push is dropped when full, even if a pop happens in the same cycle.
module div_req_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents are don't-care while the slot is not counted.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_req_sequencer.sv
// Control stage in front of the sequential divider. Requests are queued,
// trivial cases (zero divisor, zero dividend) are answered locally, and the
// rest are run one at a time on the divider with error/timeout recovery.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready
// are both high. Once raised, out_valid and its payload stay stable until
// the transfer; in_ready only depends on FIFO occupancy.
module div_req_sequencer
    import div_pkg::*;
#(
    parameter int L_DIVN     = DEF_L_DIVN,
    parameter int L_DIVR     = DEF_L_DIVR,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int L_TO       = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [L_DIVN-1:0] in_dividend,
    input  logic [L_DIVR-1:0] in_divisor,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [L_DIVN-1:0] div_word1,
    output logic [L_DIVR-1:0] div_word2,
    output logic              div_start,
    output logic              div_reset,
    input  logic              div_ready,
    input  logic              div_error,
    input  logic [L_DIVN-1:0] div_quotient,
    input  logic [L_DIVN-1:0] div_remainder,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [L_DIVN-1:0] out_quotient,
    output logic [L_DIVN-1:0] out_remainder,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        out_err,
    output logic [2:0]        dbg_state
);

    localparam int FW = L_DIVN + L_DIVR + TAG_W;
    localparam logic [L_TO-1:0] TO_LAST = L_TO'(TIMEOUT - 1);

    div_state_e        state;
    logic [L_TO-1:0]   to_cnt;
    logic              rcv_cnt;
    logic              timed_out;

    logic [FW-1:0]     head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [L_DIVN-1:0] head_dividend;
    logic [L_DIVR-1:0] head_divisor;
    logic [TAG_W-1:0]  head_tag;

    assign {head_dividend, head_divisor, head_tag} = head;

    assign in_ready  = !fifo_full;
    assign pop       = (state == S_IDLE) && !fifo_empty;
    assign timed_out = (to_cnt == TO_LAST);
    // Start is only ever a same-cycle echo of Ready while in ISSUE.
    assign div_start = (state == S_ISSUE) && div_ready;
    assign dbg_state = state;

    div_req_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop),
        .wdata ({in_dividend, in_divisor, in_tag}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Request FSM with timeout counter, divider reset pulse and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            to_cnt        <= '0;
            rcv_cnt       <= 1'b0;
            div_word1     <= '0;
            div_word2     <= '0;
            div_reset     <= 1'b1;
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_tag       <= '0;
            out_err       <= ERR_OK;
        end else begin
            // Divider reset is a pulse; only RECOVER keeps it asserted.
            div_reset <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        div_word1     <= head_dividend;
                        div_word2     <= head_divisor;
                        out_tag       <= head_tag;
                        out_quotient  <= '0;
                        out_remainder <= '0;
                        to_cnt        <= '0;
                        if (head_divisor == '0) begin
                            out_err   <= ERR_DIV0;
                            out_valid <= 1'b1;
                            state     <= S_HOLD;
                        end else if (head_dividend == '0) begin
                            out_err   <= ERR_OK;
                            out_valid <= 1'b1;
                            state     <= S_HOLD;
                        end else begin
                            out_err <= ERR_OK;
                            state   <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (div_ready) begin
                        state <= S_WAIT_BUSY;
                    end else if (timed_out) begin
                        out_err   <= ERR_TIMEOUT;
                        div_reset <= 1'b1;
                        rcv_cnt   <= 1'b0;
                        state     <= S_RECOVER;
                    end
                end

                S_WAIT_BUSY: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (div_error) begin
                        out_err   <= ERR_DIVERR;
                        div_reset <= 1'b1;
                        rcv_cnt   <= 1'b0;
                        state     <= S_RECOVER;
                    end else if (!div_ready) begin
                        state <= S_WAIT_DONE;
                    end else if (timed_out) begin
                        out_err   <= ERR_TIMEOUT;
                        div_reset <= 1'b1;
                        rcv_cnt   <= 1'b0;
                        state     <= S_RECOVER;
                    end
                end

                S_WAIT_DONE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (div_error) begin
                        out_err   <= ERR_DIVERR;
                        div_reset <= 1'b1;
                        rcv_cnt   <= 1'b0;
                        state     <= S_RECOVER;
                    end else if (div_ready) begin
                        out_quotient  <= div_quotient;
                        out_remainder <= div_remainder;
                        out_err       <= ERR_OK;
                        out_valid     <= 1'b1;
                        state         <= S_HOLD;
                    end else if (timed_out) begin
                        out_err   <= ERR_TIMEOUT;
                        div_reset <= 1'b1;
                        rcv_cnt   <= 1'b0;
                        state     <= S_RECOVER;
                    end
                end

                S_RECOVER: begin
                    // Two cycles of divider reset, then report the failure.
                    if (rcv_cnt) begin
                        div_reset <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        div_reset <= 1'b1;
                        rcv_cnt   <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed bench for div_req_sequencer with a behavioural divider model.
module tb_div_req_sequencer;

    localparam int L_DIVN = 8;
    localparam int L_DIVR = 4;
    localparam int TAG_W  = 4;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [L_DIVN-1:0] in_dividend;
    logic [L_DIVR-1:0] in_divisor;
    logic [TAG_W-1:0]  in_tag;
    logic [L_DIVN-1:0] div_word1;
    logic [L_DIVR-1:0] div_word2;
    logic              div_start;
    logic              div_reset;
    logic              div_ready;
    logic              div_error;
    logic [L_DIVN-1:0] div_quotient;
    logic [L_DIVN-1:0] div_remainder;
    logic              out_valid;
    logic              out_ready;
    logic [L_DIVN-1:0] out_quotient;
    logic [L_DIVN-1:0] out_remainder;
    logic [TAG_W-1:0]  out_tag;
    logic [1:0]        out_err;
    logic [2:0]        dbg_state;

    int vectors;
    int miscompares;
    int start_cnt;
    int start_viol;
    int rst_run;
    int last_run;
    int mode;       // 0 normal, 1 raise error, 2 hang
    int m_cnt;

    div_req_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_tag        (in_tag),
        .div_word1     (div_word1),
        .div_word2     (div_word2),
        .div_start     (div_start),
        .div_reset     (div_reset),
        .div_ready     (div_ready),
        .div_error     (div_error),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_tag       (out_tag),
        .out_err       (out_err),
        .dbg_state     (dbg_state)
    );

    // Clock generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divider model: Ready drops on Start and returns 10 cycles later
    always @(posedge clock) begin
        if (div_reset) begin
            div_ready <= 1'b1;
            div_error <= 1'b0;
            m_cnt     <= 0;
        end else if (div_ready && div_start) begin
            div_ready <= 1'b0;
            m_cnt     <= 10;
            if (div_word2 != 0) begin
                div_quotient  <= div_word1 / L_DIVN'(div_word2);
                div_remainder <= div_word1 % L_DIVN'(div_word2);
            end
        end else if (!div_ready && !div_error && mode != 2) begin
            if (m_cnt == 1) begin
                if (mode == 1) div_error <= 1'b1;
                else div_ready <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Monitor Start pulses and the length of divider reset pulses
    always @(negedge clock) begin
        if (div_start) start_cnt++;
        if (div_start && dbg_state != 3'd1) start_viol++;
        if (div_reset) rst_run++;
        else begin
            if (rst_run != 0) last_run = rst_run;
            rst_run = 0;
        end
    end

    task automatic push(input logic [L_DIVN-1:0] d, input logic [L_DIVR-1:0] v,
                        input logic [TAG_W-1:0] t, output bit acc);
        in_valid    = 1'b1;
        in_dividend = d;
        in_divisor  = v;
        in_tag      = t;
        acc         = in_ready;
        @(posedge clock); #1;
        in_valid    = 1'b0;
    endtask

    task automatic wait_out(input int max, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < max) begin
            @(posedge clock); #1;
            cyc++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            $display("FAIL wait_out: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
            miscompares++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (in_ready !== 1'b1 || div_reset !== 1'b1 || out_valid !== 1'b0 || div_start !== 1'b0) begin
            $display("FAIL reset_flags: in_ready=%b div_reset=%b out_valid=%b div_start=%b, required 1 1 0 0",
                     in_ready, div_reset, out_valid, div_start);
            miscompares++;
        end
        vectors++;
        if (out_err !== 2'd0 || out_tag !== 4'd0 || out_quotient !== 8'd0 || div_word1 !== 8'd0) begin
            $display("FAIL reset_data: err=%0d tag=%0d q=%0d w1=%0d, required all 0",
                     out_err, out_tag, out_quotient, div_word1);
            miscompares++;
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        vectors++;
        if (div_reset !== 1'b1) begin
            $display("FAIL reset_release: div_reset=%b, required 1", div_reset);
            miscompares++;
        end
        @(posedge clock); #1;
        vectors++;
        if (div_reset !== 1'b0) begin
            $display("FAIL reset_pulse_end: div_reset=%b, required 0", div_reset);
            miscompares++;
        end
    endtask

    task automatic test_divide();
        bit acc;
        int cyc;
        int s0;
        s0 = start_cnt;
        push(8'd200, 4'd7, 4'd3, acc);
        wait_out(40, cyc);
        vectors++;
        if (cyc != 13) begin
            $display("FAIL divide_latency: %0d cycles, required 13", cyc);
            miscompares++;
        end
        vectors++;
        if (out_quotient !== 8'd28 || out_remainder !== 8'd4 || out_tag !== 4'd3 || out_err !== 2'd0) begin
            $display("FAIL divide_result: q=%0d r=%0d tag=%0d err=%0d, required 28 4 3 0",
                     out_quotient, out_remainder, out_tag, out_err);
            miscompares++;
        end
        vectors++;
        if (div_word1 !== 8'd200 || div_word2 !== 4'd7 || start_cnt - s0 != 1) begin
            $display("FAIL divide_issue: w1=%0d w2=%0d starts=%0d, required 200 7 1",
                     div_word1, div_word2, start_cnt - s0);
            miscompares++;
        end
        consume();
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL divide_consume: out_valid=%b, required 0", out_valid);
            miscompares++;
        end
    endtask

    task automatic test_trivial(input logic [L_DIVN-1:0] d, input logic [L_DIVR-1:0] v,
                                input logic [TAG_W-1:0] t, input logic [1:0] exp_err);
        bit acc;
        int s0;
        s0 = start_cnt;
        push(d, v, t, acc);
        @(posedge clock); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_quotient !== 8'd0 || out_remainder !== 8'd0 ||
            out_err !== exp_err || out_tag !== t) begin
            $display("FAIL trivial_%0d: valid=%b q=%0d r=%0d err=%0d tag=%0d, required 1 0 0 %0d %0d",
                     t, out_valid, out_quotient, out_remainder, out_err, out_tag, exp_err, t);
            miscompares++;
        end
        vectors++;
        if (start_cnt != s0) begin
            $display("FAIL trivial_start_%0d: starts=%0d, required 0", t, start_cnt - s0);
            miscompares++;
        end
        consume();
    endtask

    task automatic test_div_error();
        bit acc;
        int cyc;
        mode = 1;
        push(8'd100, 4'd3, 4'd5, acc);
        wait_out(40, cyc);
        vectors++;
        if (out_err !== 2'b10 || out_tag !== 4'd5 || cyc != 15) begin
            $display("FAIL diverr_result: err=%0d tag=%0d cycles=%0d, required 2 5 15", out_err, out_tag, cyc);
            miscompares++;
        end
        mode = 0;
        consume();
        vectors++;
        if (last_run != 2) begin
            $display("FAIL diverr_reset_len: %0d cycles, required 2", last_run);
            miscompares++;
        end
        push(8'd50, 4'd6, 4'd6, acc);
        wait_out(40, cyc);
        vectors++;
        if (out_quotient !== 8'd8 || out_remainder !== 8'd2 || out_tag !== 4'd6 || out_err !== 2'd0) begin
            $display("FAIL diverr_next: q=%0d r=%0d tag=%0d err=%0d, required 8 2 6 0",
                     out_quotient, out_remainder, out_tag, out_err);
            miscompares++;
        end
        consume();
    endtask

    task automatic test_timeout();
        bit acc;
        int cyc;
        mode = 2;
        push(8'd77, 4'd5, 4'd7, acc);
        push(8'd9, 4'd2, 4'd8, acc);
        wait_out(100, cyc);
        vectors++;
        if (out_err !== 2'b11 || out_tag !== 4'd7 || out_quotient !== 8'd0 || out_remainder !== 8'd0) begin
            $display("FAIL timeout_result: err=%0d tag=%0d q=%0d r=%0d, required 3 7 0 0",
                     out_err, out_tag, out_quotient, out_remainder);
            miscompares++;
        end
        vectors++;
        if (cyc != 66) begin
            $display("FAIL timeout_latency: %0d cycles, required 66", cyc);
            miscompares++;
        end
        mode = 0;
        consume();
        vectors++;
        if (last_run != 2) begin
            $display("FAIL timeout_reset_len: %0d cycles, required 2", last_run);
            miscompares++;
        end
        wait_out(40, cyc);
        vectors++;
        if (out_quotient !== 8'd4 || out_remainder !== 8'd1 || out_tag !== 4'd8 || out_err !== 2'd0) begin
            $display("FAIL timeout_next: q=%0d r=%0d tag=%0d err=%0d, required 4 1 8 0",
                     out_quotient, out_remainder, out_tag, out_err);
            miscompares++;
        end
        consume();
    endtask

    task automatic test_backpressure();
        logic [TAG_W-1:0] exp_q[$];
        logic [TAG_W-1:0] exp_tag;
        bit acc;
        int n_acc;
        int cyc;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            push(8'd0, 4'd1, TAG_W'(10 + i), acc);
            if (acc) begin
                n_acc++;
                exp_q.push_back(TAG_W'(10 + i));
            end
        end
        vectors++;
        if (n_acc != 5 || in_ready !== 1'b0) begin
            $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 5 0", n_acc, in_ready);
            miscompares++;
        end
        for (int i = 0; i < 5; i++) begin
            wait_out(10, cyc);
            exp_tag = exp_q.pop_front();
            vectors++;
            if (out_tag !== exp_tag || out_err !== 2'd0) begin
                $display("FAIL bp_order_%0d: tag=%0d err=%0d, required %0d 0", i, out_tag, out_err, exp_tag);
                miscompares++;
            end
            consume();
        end
        repeat (5) @(posedge clock);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL bp_drained: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
            miscompares++;
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        int cyc;
        int seen;
        push(8'd200, 4'd7, 4'd9, acc);
        push(8'd0, 4'd1, 4'd11, acc);
        cyc = 0;
        while (dbg_state != 3'd3 && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        vectors++;
        if (dbg_state !== 3'd3) begin
            $display("FAIL areset_reach: state=%0d, required 3", dbg_state);
            miscompares++;
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || div_reset !== 1'b1 || dbg_state !== 3'd0) begin
            $display("FAIL areset_now: out_valid=%b in_ready=%b div_reset=%b state=%0d, required 0 1 1 0",
                     out_valid, in_ready, div_reset, dbg_state);
            miscompares++;
        end
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            $display("FAIL areset_stale: out_valid high %0d cycles, required 0", seen);
            miscompares++;
        end
        push(8'd90, 4'd9, 4'd12, acc);
        wait_out(40, cyc);
        vectors++;
        if (out_quotient !== 8'd10 || out_remainder !== 8'd0 || out_tag !== 4'd12 || out_err !== 2'd0) begin
            $display("FAIL areset_after: q=%0d r=%0d tag=%0d err=%0d, required 10 0 12 0",
                     out_quotient, out_remainder, out_tag, out_err);
            miscompares++;
        end
        consume();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        start_cnt   = 0;
        start_viol  = 0;
        rst_run     = 0;
        last_run    = 0;
        mode        = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_tag      = '0;
        out_ready   = 1'b0;

        test_reset();
        test_divide();
        test_trivial(8'd55, 4'd0, 4'd1, 2'b01);
        test_trivial(8'd0, 4'd5, 4'd2, 2'b00);
        test_div_error();
        test_timeout();
        test_backpressure();
        test_async_reset();

        vectors++;
        if (start_viol != 0) begin
            $display("FAIL start_outside_issue: %0d pulses, required 0", start_viol);
            miscompares++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_req_sequencer.md
Name: div_req_sequencer

Overview:
Upstream/downstream control stage for the sequential divider. Buffers operand pairs in a small FIFO and screens out trivial cases: zero divisor and zero dividend. For all other pairs it drives the divider's word1/word2/Start, waits for completion, and captures quotient/remainder. Results go out on a valid/ready port with a tag and an error code. Divider Error or a hang is cleared by pulsing the divider's reset.

Parameters:
L_DIVN, 8, dividend/quotient/remainder width (matches divider L_divn)
L_DIVR, 4, divisor width (matches divider L_divr)
TAG_W, 4, request tag width
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
TIMEOUT, 64, max cycles from div_start to completion before abort
L_TO, 7, timeout counter width (2^L_TO > TIMEOUT)

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_dividend  in  L_DIVN  dividend
in_divisor  in  L_DIVR  divisor
in_tag  in  TAG_W  request tag
div_word1  out  L_DIVN  to divider word1
div_word2  out  L_DIVR  to divider word2
div_start  out  1  to divider Start, one-cycle pulse
div_reset  out  1  to divider reset (synchronous in divider)
div_ready  in  1  divider Ready
div_error  in  1  divider Error (sticky until divider reset)
div_quotient  in  L_DIVN  divider quotient
div_remainder  in  L_DIVN  divider remainder
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&&out_ready
out_quotient  out  L_DIVN  result quotient
out_remainder  out  L_DIVN  result remainder
out_tag  out  TAG_W  tag of the originating request
out_err  out  2  00 ok, 01 divide-by-zero, 10 divider error, 11 timeout

Behaviour:
- Reset (async, immediate): FIFO empty; FSM IDLE; all outputs 0 except in_ready=1 and div_reset=1. div_reset stays 1 for the first cycle after reset deassertion, then 0.
- FIFO:
  - in_ready = !full. There is no push-through-when-full, even on a same-cycle pop.
  - Push and pop in the same cycle are legal when not full.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly preserved.
- div_word1/div_word2 are registered from the popped entry and held stable from ISSUE until the next pop.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head. Screening on the popped entry:
    - divisor==0: result q=0, r=0, err=01, go to HOLD; no div_start.
    - dividend==0: q=0, r=0, err=00, go to HOLD; no div_start.
    - otherwise: go to ISSUE; timeout counter cleared.
  - ISSUE:
    - div_ready=1: div_start=1 for this single cycle, go to WAIT_BUSY.
    - div_ready=0: stay.
  - WAIT_BUSY: waits for div_ready=0, i.e. the divider has left idle.
    - div_error=1: go to RECOVER, err=10. This takes priority over all other conditions.
  - WAIT_DONE:
    - div_error=1: RECOVER, err=10.
    - else div_ready=1: capture div_quotient and div_remainder, err=00, go to HOLD.
  - Timeout: counter increments every cycle in ISSUE/WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT-1 with no completion: RECOVER, err=11, q=r=0.
  - RECOVER: div_reset=1 for exactly 2 cycles, then go to HOLD.
  - HOLD: out_valid=1 with q/r/tag/err stable. On out_ready, go to IDLE; the next pop can happen no earlier than the following cycle.
- Latency: the trivial cases give out_valid 1 cycle after the pop cycle. The divide case gives out_valid 1 cycle after the div_ready rising edge is sampled in WAIT_DONE.
- Only one divide is in flight at a time. div_start is never asserted outside ISSUE.
- out_ready held low: the FSM waits in HOLD; the FIFO keeps accepting until full.
- An async reset mid-operation discards the FIFO contents and any in-flight result. No stale out_valid appears after reset.

Decomposition:
- Shared package div_pkg:
  - L_DIVN, L_DIVR, TAG_W defaults
  - FSM state encoding: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RECOVER, HOLD
  - out_err code constants: ERR_OK, ERR_DIV0, ERR_DIVERR, ERR_TIMEOUT
- Sub-module div_req_fifo: parameterised sync FIFO of {dividend, divisor, tag}, with full/empty flags.
- The FSM, timeout counter and result registers live in the top level.

Test Plan:
- Push (200, 7, tag 3); divider model asserts Ready 10 cycles after Start with q=28, r=4 -> exactly one div_start pulse, word1=200, word2=7; out q=28, r=4, tag=3, err=00.
- Push (55, 0, tag 1) -> no div_start; out_valid 1 cycle after pop with q=0, r=0, err=01.
- Push (0, 5, tag 2) -> no div_start; q=0, r=0, err=00.
- Model raises div_error in WAIT_DONE -> div_reset high for exactly 2 cycles; out err=10, tag preserved; the next request issues normally.
- Model never returns Ready -> after TIMEOUT cycles, div_reset for 2 cycles, err=11; then a queued request completes with err=00.
- out_ready held low while pushing 6 requests -> in_ready falls after 4 accepted plus 1 in HOLD. Releasing out_ready delivers tags in push order. Async reset asserted mid-WAIT_DONE -> out_valid=0 and in_ready=1 immediately, FIFO empty.
